pad_input_debounce: RTL and testbench

// Pad-to-core receive path for general-purpose input pins: the input side that

---
 rtl/pad_input_debounce_pkg.sv | 22 ++
 rtl/pad_debounce_bit.sv | 127 ++++++++++++
 rtl/pad_input_debounce.sv | 47 ++++
 tb/tb_pad_input_debounce.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pad_input_debounce_pkg.sv
// Shared definitions for the pad input debounce path.
//   - db_state_e : implicit per-bit filter state (STABLE when the counter is
//                  idle, CHECKING while a differing level is being qualified)
//   - cnt_width  : counter width that can represent 0..DEBOUNCE_CYCLES
package pad_input_debounce_pkg;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_CHECKING = 1'b1
    } db_state_e;

    // Width of the consecutive-sample counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = (cycles < 1) ? 1 : $clog2(cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pad_debounce_bit.sv
// Single-bit pad receive path: synchroniser chain, consecutive-sample
// debounce counter, registered level, one-cycle edge strobes and a sticky
// change flag.
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_pad     : raw pad level, asynchronous to i_clk
//   i_clear   : clears o_changed (a same-edge change still sets it)
//   o_level   : debounced level
//   o_rise    : one-cycle pulse when o_level goes 0->1
//   o_fall    : one-cycle pulse when o_level goes 1->0
//   o_changed : sticky, set on any o_level change
module pad_debounce_bit
    import pad_input_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_BIT       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pad,
    input  logic i_clear,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_changed
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   changed_q, changed_d;

    logic      sample_c;
    logic      differ_c;
    logic      accept_c;
    db_state_e state_c;

    // Synchroniser shift: pad enters at bit 0, the filter reads the top bit.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_pad};
    end

    assign sample_c = sync_q[SYNC_STAGES-1];
    assign differ_c = sample_c ^ level_q;

    // Debounce filter, edge strobes and sticky flag.
    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        changed_d = changed_q;
        accept_c  = 1'b0;
        state_c   = (cnt_q == '0) ? DB_STABLE : DB_CHECKING;

        case (state_c)
            DB_STABLE: begin
                if (differ_c) begin
                    // With a single-cycle filter the first differing sample is accepted.
                    if (cnt_q >= CNT_LAST) begin
                        accept_c = 1'b1;
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                end
            end
            DB_CHECKING: begin
                if (!differ_c) begin
                    // A matching sample is a glitch: restart qualification.
                    cnt_d = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    accept_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        if (accept_c) begin
            level_d = sample_c;
            cnt_d   = '0;
            rise_d  = sample_c;
            fall_d  = ~sample_c;
        end

        // Set takes priority over clear so a change on the clearing edge is kept.
        if (i_clear) begin
            changed_d = 1'b0;
        end
        if (accept_c) begin
            changed_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q    <= {SYNC_STAGES{RESET_BIT}};
            cnt_q     <= '0;
            level_q   <= RESET_BIT;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign o_level   = level_q;
    assign o_rise    = rise_q;
    assign o_fall    = fall_q;
    assign o_changed = changed_q;

endmodule

// File: rtl/pad_input_debounce.sv
// Pad-to-core receive path for WIDTH general-purpose inputs. Each bit is
// synchronised into i_clk and debounced independently.
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_pad     : raw pad levels (WIDTH)
//   i_clear   : per-bit clear of o_changed (WIDTH)
//   o_level   : debounced levels (WIDTH)
//   o_rise    : per-bit one-cycle rising-edge strobe (WIDTH)
//   o_fall    : per-bit one-cycle falling-edge strobe (WIDTH)
//   o_changed : per-bit sticky change flag (WIDTH)
module pad_input_debounce
    import pad_input_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH           = 1,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_pad,
    input  logic [WIDTH-1:0] i_clear,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_changed
);

    // One independent filter per input bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pad_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_LEVEL[i])
        ) u_bit (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_pad    (i_pad[i]),
            .i_clear  (i_clear[i]),
            .o_level  (o_level[i]),
            .o_rise   (o_rise[i]),
            .o_fall   (o_fall[i]),
            .o_changed(o_changed[i])
        );
    end

endmodule

// File: tb/tb_pad_input_debounce.sv
module tb_pad_input_debounce;

    logic       i_clk;
    logic       i_rst_n;
    logic [1:0] i_pad;
    logic [1:0] i_clear;
    logic [1:0] o_level;
    logic [1:0] o_rise;
    logic [1:0] o_fall;
    logic [1:0] o_changed;

    int tests_run;
    int tests_failed;

    pad_input_debounce #(
        .WIDTH          (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .RESET_LEVEL    (2'b00)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_pad    (i_pad),
        .i_clear  (i_clear),
        .o_level  (o_level),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_changed(o_changed)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Compare {level, rise, fall, changed} against the expected vector.
    task automatic check(input string tag, input logic [1:0] lvl, input logic [1:0] rise,
                         input logic [1:0] fall, input logic [1:0] chg);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {o_level, o_rise, o_fall, o_changed};
        exp = {lvl, rise, fall, chg};
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed lvl/rise/fall/chg=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] el, er, ef, ec;
        tests_run    = 0;
        tests_failed = 0;
        i_rst_n = 1'b0;
        i_pad   = 2'b00;
        i_clear = 2'b00;

        // Reset state
        #12;
        check("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Glitch: three cycles high is one sample short of acceptance
        i_pad[0] = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 3) i_pad[0] = 1'b0;
            check($sformatf("glitch_t%0d", t), 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Clean step on bit0: accepted on edge 6
        i_pad[0] = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            el = (t >= 6) ? 2'b01 : 2'b00;
            er = (t == 6) ? 2'b01 : 2'b00;
            ec = (t >= 6) ? 2'b01 : 2'b00;
            check($sformatf("step_t%0d", t), el, er, 2'b00, ec);
        end

        // Plain clear of bit0
        i_clear = 2'b01;
        tick();
        i_clear = 2'b00;
        check("clear0", 2'b01, 2'b00, 2'b00, 2'b00);

        // Bouncing on bit1: 1,0,1,1,0 then steady 1 -> single rise at edge 11
        begin
            logic [10:0] pat;
            pat = 11'b111_1110_1101; // LSB first: 1,0,1,1,0,1,1,...
            i_pad[1] = pat[0];
            for (int t = 1; t <= 12; t++) begin
                tick();
                i_pad[1] = (t < 11) ? pat[t] : 1'b1;
                el = (t >= 11) ? 2'b11 : 2'b01;
                er = (t == 11) ? 2'b10 : 2'b00;
                ec = (t >= 11) ? 2'b10 : 2'b00;
                check($sformatf("bounce_t%0d", t), el, er, 2'b00, ec);
            end
        end

        // Clear race: clear on the same edge as fall[0]; set must win
        i_pad[0] = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 5) i_clear = 2'b01;
            el = (t >= 6) ? 2'b10 : 2'b11;
            ef = (t == 6) ? 2'b01 : 2'b00;
            ec = (t >= 6) ? 2'b11 : 2'b10;
            check($sformatf("race_t%0d", t), el, 2'b00, ef, ec);
        end
        i_clear = 2'b00;
        tick();
        check("race_after", 2'b10, 2'b00, 2'b00, 2'b11);
        i_clear = 2'b01;
        tick();
        i_clear = 2'b00;
        check("race_clear_alone", 2'b10, 2'b00, 2'b00, 2'b10);

        i_clear = 2'b11;
        tick();
        i_clear = 2'b00;
        check("clear_all", 2'b10, 2'b00, 2'b00, 2'b00);

        // Independence: bit0 rises now, bit1 falls two cycles later
        i_pad[0] = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (t == 2) i_pad[1] = 1'b0;
            el = {(t < 8) ? 1'b1 : 1'b0, (t >= 6) ? 1'b1 : 1'b0};
            er = (t == 6) ? 2'b01 : 2'b00;
            ef = (t == 8) ? 2'b10 : 2'b00;
            ec = {(t >= 8) ? 1'b1 : 1'b0, (t >= 6) ? 1'b1 : 1'b0};
            check($sformatf("indep_t%0d", t), el, er, ef, ec);
        end

        // Reset mid-count on bit1 (count reaches 2 after edge 4)
        i_pad[1] = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            check($sformatf("prerst_t%0d", t), 2'b01, 2'b00, 2'b00, 2'b11);
        end
        i_rst_n = 1'b0;
        #2;
        check("async_reset", 2'b00, 2'b00, 2'b00, 2'b00);
        @(posedge i_clk);
        #1;
        check("reset_held", 2'b00, 2'b00, 2'b00, 2'b00);
        i_rst_n = 1'b1;

        // Pad held at 11 after release: both bits rise on edge 6
        for (int t = 1; t <= 7; t++) begin
            tick();
            el = (t >= 6) ? 2'b11 : 2'b00;
            er = (t == 6) ? 2'b11 : 2'b00;
            ec = (t >= 6) ? 2'b11 : 2'b00;
            check($sformatf("postrst_t%0d", t), el, er, 2'b00, ec);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
